// File: rtl/perf_run_ctrl_pkg.sv
// Shared types and defaults for the performance-run controller.
package perf_run_ctrl_pkg;

  // Default width of the cycle and retired-instruction counters.
  localparam int CW_DEFAULT = 16;

  // Run controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } run_state_e;

endpackage

// File: rtl/perf_run_ctrl_if.sv
// Handshake bundle between the pipeline/host and the run controller.
// The slave modport is the controller side, the master modport is the
// pipeline/host side that issues start and reports retirement status.
interface perf_run_ctrl_if
  import perf_run_ctrl_pkg::*;
#(
  parameter int CW = CW_DEFAULT
);
  logic          start;
  logic          isHalt;
  logic          W_v;
  logic          pipe_empty;
  logic          fetch_en;
  logic          run;
  logic          flush;
  logic [CW-1:0] cycle;
  logic [CW-1:0] instr;
  logic          done;
  logic          timeout;

  modport slave (
    input  start, isHalt, W_v, pipe_empty,
    output fetch_en, run, flush, cycle, instr, done, timeout
  );

  modport master (
    output start, isHalt, W_v, pipe_empty,
    input  fetch_en, run, flush, cycle, instr, done, timeout
  );
endinterface

// File: rtl/perf_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] q
);
  localparam logic [CW-1:0] Q_MAX = {CW{1'b1}};

  logic [CW-1:0] cnt_r;

  // Count register: clear wins over increment, increment stops at Q_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (inc && (cnt_r != Q_MAX)) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign q = cnt_r;
endmodule

// File: rtl/perf_run_ctrl.sv
// Performance-run controller: flushes the pipeline, runs it until HALT
// retires or the cycle budget is exhausted, drains in-flight work and
// reports cycle/instruction counts. Outputs are registered copies of the
// next-state decode, so they behave as Moore outputs of the state register.
module perf_run_ctrl
  import perf_run_ctrl_pkg::*;
#(
  parameter int CW         = CW_DEFAULT,
  parameter int MAX_CYCLES = 10000,
  parameter int DRAIN_MAX  = 8
) (
  input logic             clk,
  input logic             rst_n,
  perf_run_ctrl_if.slave  bus
);
  localparam int              DW         = $clog2(DRAIN_MAX) + 1;
  localparam logic [CW-1:0]   CYC_LAST   = CW'(MAX_CYCLES - 1);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_MAX - 1);

  run_state_e    state_r;
  run_state_e    state_nxt_s;
  logic [DW-1:0] drain_cnt_r;
  logic          timeout_r;
  logic          fetch_en_r;
  logic          run_r;
  logic          flush_r;
  logic          done_r;
  logic [CW-1:0] cycle_s;
  logic [CW-1:0] instr_s;
  logic          cnt_clr_s;
  logic          cyc_inc_s;
  logic          ins_inc_s;
  logic          budget_hit_s;

  assign cnt_clr_s    = (state_r == ST_FLUSH);
  assign cyc_inc_s    = (state_r == ST_RUN);
  assign ins_inc_s    = bus.W_v && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
  assign budget_hit_s = (cycle_s == CYC_LAST);

  sat_counter #(.CW(CW)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_s),
    .inc   (cyc_inc_s),
    .q     (cycle_s)
  );

  sat_counter #(.CW(CW)) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_s),
    .inc   (ins_inc_s),
    .q     (instr_s)
  );

  // Next-state decode; HALT takes priority over the cycle budget.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_nxt_s = ST_FLUSH;
        else           state_nxt_s = ST_IDLE;
      end
      ST_FLUSH: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (bus.isHalt)        state_nxt_s = ST_DRAIN;
        else if (budget_hit_s) state_nxt_s = ST_DONE;
        else                   state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (bus.pipe_empty || (drain_cnt_r == DRAIN_LAST)) state_nxt_s = ST_DONE;
        else                                               state_nxt_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (bus.start) state_nxt_s = ST_FLUSH;
        else           state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Drain cycle counter: cleared by the flush, advances every DRAIN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    drain_cnt_r <= {DW{1'b0}};
    else if (state_r == ST_FLUSH)  drain_cnt_r <= {DW{1'b0}};
    else if (state_r == ST_DRAIN)  drain_cnt_r <= drain_cnt_r + {{(DW-1){1'b0}}, 1'b1};
    else                           drain_cnt_r <= drain_cnt_r;
  end

  // Timeout flag: set only when the budget ends RUN without a HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   timeout_r <= 1'b0;
    else if (state_r == ST_FLUSH) timeout_r <= 1'b0;
    else if ((state_r == ST_RUN) && !bus.isHalt && budget_hit_s) timeout_r <= 1'b1;
    else                          timeout_r <= timeout_r;
  end

  // Control outputs registered from the next state so they track state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_en_r <= 1'b0;
      run_r      <= 1'b0;
      flush_r    <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      fetch_en_r <= (state_nxt_s == ST_RUN);
      run_r      <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
      flush_r    <= (state_nxt_s == ST_FLUSH);
      done_r     <= (state_nxt_s == ST_DONE);
    end
  end

  assign bus.fetch_en = fetch_en_r;
  assign bus.run      = run_r;
  assign bus.flush    = flush_r;
  assign bus.done     = done_r;
  assign bus.timeout  = timeout_r;
  assign bus.cycle    = cycle_s;
  assign bus.instr    = instr_s;
endmodule

// File: tb/tb_perf_run_ctrl.sv
// Directed, table-driven bench for perf_run_ctrl (MAX_CYCLES=100, DRAIN_MAX=8).
module tb_perf_run_ctrl;
  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  perf_run_ctrl_if #(.CW(16)) bus ();

  perf_run_ctrl #(.CW(16), .MAX_CYCLES(100), .DRAIN_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic       sc_clr;
  logic       sc_inc;
  logic [2:0] sc_q;

  sat_counter #(.CW(3)) u_sc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sc_clr),
    .inc   (sc_inc),
    .q     (sc_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        halt;
    logic        wv;
    logic        pe;
    logic [36:0] exp;
  } vec_t;

  vec_t vecs[14];

  // {fetch_en, run, flush, done, timeout, cycle, instr}
  function automatic logic [36:0] mk(input logic fe, input logic rn, input logic fl,
                                     input logic dn, input logic to,
                                     input logic [15:0] c, input logic [15:0] i);
    return {fe, rn, fl, dn, to, c, i};
  endfunction

  function automatic logic [36:0] get_out();
    return {bus.fetch_en, bus.run, bus.flush, bus.done, bus.timeout, bus.cycle, bus.instr};
  endfunction

  task automatic check(input string name, input logic [36:0] exp);
    logic [36:0] act;
    act = get_out();
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got fe/run/fl/done/to=%b cyc=%0d ins=%0d, expected fe/run/fl/done/to=%b cyc=%0d ins=%0d",
               name, act[36:32], act[31:16], act[15:0], exp[36:32], exp[31:16], exp[15:0]);
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic h, input logic w, input logic p);
    bus.start      = s;
    bus.isHalt     = h;
    bus.W_v        = w;
    bus.pipe_empty = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.isHalt     = 1'b0;
    bus.W_v        = 1'b0;
    bus.pipe_empty = 1'b0;
    sc_clr         = 1'b0;
    sc_inc         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // start pulse from IDLE/DONE, then the flush cycle; leaves DUT in RUN with zeroed counters
  task automatic start_run();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tests  = 0;
    failed = 0;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0)};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0)};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0)};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1)};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1)};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 16'd2)};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 16'd3)};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 16'd4)};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 16'd4)};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 16'd4)};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 16'd4)};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 16'd4)};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0)};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1)};

    do_reset();
    check("reset_state", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));

    for (int v = 0; v < 14; v++) begin
      step(vecs[v].start, vecs[v].halt, vecs[v].wv, vecs[v].pe);
      check($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Halt on RUN cycle 20 with W_v every cycle, pipe empty right after
    do_reset();
    start_run();
    for (int i = 1; i <= 20; i++) step(1'b0, (i == 20), 1'b1, 1'b0);
    check("halt20_drain", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd20, 16'd20));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("halt20_done", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd20, 16'd20));

    // Budget exhaustion without HALT
    do_reset();
    start_run();
    for (int i = 1; i <= 99; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("budget_99_running", mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd99, 16'd99));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("budget_timeout", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd100, 16'd100));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("budget_hold", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd100, 16'd100));
    // restart from DONE clears timeout and counters after the flush
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_flush", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd100, 16'd100));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_cleared", mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));

    // HALT on the same cycle as the budget: HALT wins
    do_reset();
    start_run();
    for (int i = 1; i <= 100; i++) step(1'b0, (i == 100), 1'b0, 1'b0);
    check("halt_vs_budget_drain", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd100, 16'd0));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("halt_vs_budget_done", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd100, 16'd0));

    // Drain limit with pipe never empty; W_v pulses on odd drain cycles
    do_reset();
    start_run();
    for (int i = 1; i <= 5; i++) step(1'b0, (i == 5), 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, k[0], 1'b0);
      if (k == 7) check("drain_k7", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 16'd9));
    end
    check("drain_limit_done", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5, 16'd9));

    // Asynchronous reset in the middle of RUN at cycle 37
    do_reset();
    start_run();
    for (int i = 1; i <= 37; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("pre_reset_37", mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd37, 16'd37));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("post_reset_idle", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("post_reset_flush", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0));

    // Saturating counter stops at all-ones
    sc_inc = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("sat_count6", {29'd0, sc_q}, 32'd6);
    repeat (4) @(posedge clk);
    #1;
    check_eq("sat_hold", {29'd0, sc_q}, 32'd7);
    sc_inc = 1'b0;
    sc_clr = 1'b1;
    @(posedge clk);
    #1;
    sc_clr = 1'b0;
    check_eq("sat_clear", {29'd0, sc_q}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/perf_run_ctrl.md
PERF_RUN_CTRL -- requirements
Module: perf_run_ctrl

Interface
REQ-001 Parameter: CW, 16, width of cycle and instruction counters.
REQ-002 Parameter: MAX_CYCLES, 10000, cycle budget before forced stop.
REQ-003 Parameter: DRAIN_MAX, 8, max drain cycles after halt.
REQ-004 Port: clk  input  1  single clock; all state updates on posedge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: start  input  1  run request; sampled only in IDLE or DONE.
REQ-007 Port: isHalt  input  1  HALT instruction retired at writeback this cycle.
REQ-008 Port: W_v  input  1  writeback stage holds a valid retiring instruction.
REQ-009 Port: pipe_empty  input  1  no valid instruction in any pipeline stage.
REQ-010 Port: fetch_en  output  1  fetch stage may issue new instructions.
REQ-011 Port: run  output  1  global pipeline advance enable.
REQ-012 Port: flush  output  1  one-cycle pipeline flush pulse.
REQ-013 Port: cycle  output  CW  cycles spent in RUN.
REQ-014 Port: instr  output  CW  retired instructions.
REQ-015 Port: done  output  1  run finished; held until next start.
REQ-016 Port: timeout  output  1  run ended by cycle budget, not HALT; valid while done=1.

Function
REQ-017 FSM states: IDLE, FLUSH, RUN, DRAIN, DONE; state register only, outputs decoded from state and registers (Moore).
REQ-018 IDLE: fetch_en=0, run=0, flush=0; start=1 -> FLUSH next cycle.
REQ-019 FLUSH: flush=1, run=0, fetch_en=0 for exactly one cycle; cycle, instr, timeout, drain count cleared to 0; -> RUN unconditionally.
REQ-020 RUN: fetch_en=1, run=1; cycle increments by 1 every RUN cycle; instr increments by 1 on each cycle with W_v=1.
REQ-021 RUN, isHalt=1: -> DRAIN; cycle frozen at value after that cycle's increment; HALT counted in instr if W_v=1 same cycle.
REQ-022 RUN, isHalt=0 and cycle==MAX_CYCLES-1 (i.e. cycle reaches MAX_CYCLES this edge): -> DONE, timeout=1.
REQ-023 RUN, isHalt=1 and budget reached same cycle: HALT wins; -> DRAIN, timeout=0.
REQ-024 DRAIN: fetch_en=0, run=1; instr still counts W_v; cycle frozen; drain counter increments each cycle.
REQ-025 DRAIN exit: pipe_empty=1 or drain counter==DRAIN_MAX-1 -> DONE; timeout=0 in both cases.
REQ-026 DONE: done=1, run=0, fetch_en=0; cycle, instr, timeout hold; start=1 -> FLUSH (restart).
REQ-027 start ignored in FLUSH, RUN, DRAIN.
REQ-028 cycle and instr saturate at 2^CW-1; no wrap.
REQ-029 CPI is not computed in hardware; consumers divide cycle by instr.

Reset
REQ-030 rst_n=0 asynchronously forces state=IDLE, cycle=0, instr=0, drain counter=0, timeout=0.
REQ-031 Reset outputs: fetch_en=0, run=0, flush=0, done=0, timeout=0, cycle=0, instr=0.
REQ-032 Reset asserted mid-RUN or mid-DRAIN aborts the run with no done pulse; deassertion resumes in IDLE on the next clk edge.

Structure
REQ-033 Shared package holds the FSM state enum (IDLE, FLUSH, RUN, DRAIN, DONE) and CW default.
REQ-034 One sub-module, sat_counter: CW-wide, clear, increment enable, saturating; instantiated for cycle and instr.
REQ-035 Drain counter is local, width clog2(DRAIN_MAX)+1.

Verification
REQ-036 Reset, start pulse, W_v=1 for 20 RUN cycles, isHalt on cycle 20, pipe_empty=1 next cycle -> done=1, cycle=20, instr=20, timeout=0.
REQ-037 Never assert isHalt, MAX_CYCLES=100 -> done rises after RUN cycle 100, cycle=100, timeout=1, fetch_en=0.
REQ-038 isHalt on same cycle as budget (cycle 100, MAX_CYCLES=100) -> DRAIN entered, timeout=0.
REQ-039 Halt with pipe_empty held 0, DRAIN_MAX=8 -> DONE exactly 8 cycles after DRAIN entry; W_v pulses in DRAIN add to instr.
REQ-040 start during RUN ignored; start in DONE -> one-cycle flush, counters read 0 the next cycle.
REQ-041 rst_n low mid-RUN at cycle 37 -> all outputs 0 immediately (asynchronously), state IDLE.
